// File: rtl/lfsr_checker.sv
// lfsr_checker: PRBS checker for the Fibonacci LFSR pattern generator.
// Locks onto the incoming state-word stream. It then predicts each following
// valid word and flags words that differ from the prediction. Lock status,
// a per-word error strobe and a saturating error count are all registered.
module lfsr_checker #(
    parameter int             N          = 4,
    parameter logic [N-1:0]   TAPS       = 4'b1001,
    parameter int             LOCK_CNT   = 4,
    parameter int             UNLOCK_CNT = 3,
    parameter int             ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     in_word,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    // Counter widths: match_cnt only needs to hold 0..LOCK_CNT-1 and
    // miss_cnt 0..UNLOCK_CNT-1, because reaching the last value ends the phase.
    localparam int MW = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT)   : 1;
    localparam int UW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;

    localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
    localparam logic [UW-1:0]    MISS_LAST  = UW'(UNLOCK_CNT - 1);
    localparam logic [UW-1:0]    MISS_ONE   = UW'(1);
    localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Fibonacci left shift. The XOR-reduced tapped bits feed back into bit 0.
    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
        return {s[N-2:0], ^(s & TAPS)};
    endfunction

    state_t           state_r;
    logic [N-1:0]     exp_r;
    logic [MW-1:0]    match_cnt_r;
    logic [UW-1:0]    miss_cnt_r;

    logic             word_zero_s;
    logic             word_hit_s;
    logic [N-1:0]     exp_step_s;
    logic [N-1:0]     word_step_s;
    logic             match_last_s;
    logic             miss_last_s;
    logic             miss_event_s;
    logic             err_sat_s;
    logic [ERR_W-1:0] count_nxt_s;

    // Decode the sampled word against the prediction and the phase counters.
    always_comb begin
        word_zero_s  = (in_word == {N{1'b0}});
        word_hit_s   = (in_word == exp_r);
        exp_step_s   = lfsr_next(exp_r);
        word_step_s  = lfsr_next(in_word);
        match_last_s = (match_cnt_r == MATCH_LAST);
        miss_last_s  = (miss_cnt_r == MISS_LAST);
        miss_event_s = in_valid && (state_r == ST_LOCKED) && !word_hit_s;
        err_sat_s    = &err_count;
    end

    // Error counter next value. Clear overrides a simultaneous counted
    // mismatch, and the count holds once it reaches all-ones.
    always_comb begin
        count_nxt_s = err_count;
        if (clear) begin
            count_nxt_s = {ERR_W{1'b0}};
        end else if (miss_event_s && !err_sat_s) begin
            count_nxt_s = err_count + ERR_ONE;
        end else begin
            count_nxt_s = err_count;
        end
    end

    // Hunt/sync/lock state machine with registered status outputs.
    // Invalid cycles leave the machine and its prediction untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HUNT;
            exp_r       <= {N{1'b0}};
            match_cnt_r <= {MW{1'b0}};
            miss_cnt_r  <= {UW{1'b0}};
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= {ERR_W{1'b0}};
        end else begin
            err_pulse <= miss_event_s;
            err_count <= count_nxt_s;
            if (in_valid) begin
                case (state_r)
                    ST_HUNT: begin
                        // All-zero is the LFSR lock-up word and cannot seed.
                        if (!word_zero_s) begin
                            exp_r       <= word_step_s;
                            match_cnt_r <= {MW{1'b0}};
                            state_r     <= ST_SYNC;
                        end else begin
                            state_r     <= ST_HUNT;
                        end
                        locked <= 1'b0;
                    end
                    ST_SYNC: begin
                        if (word_hit_s) begin
                            exp_r <= exp_step_s;
                            if (match_last_s) begin
                                state_r     <= ST_LOCKED;
                                locked      <= 1'b1;
                                miss_cnt_r  <= {UW{1'b0}};
                                match_cnt_r <= {MW{1'b0}};
                            end else begin
                                match_cnt_r <= match_cnt_r + MATCH_ONE;
                            end
                        end else if (!word_zero_s) begin
                            // Restart the match run from this word.
                            exp_r       <= word_step_s;
                            match_cnt_r <= {MW{1'b0}};
                        end else begin
                            state_r     <= ST_HUNT;
                            match_cnt_r <= {MW{1'b0}};
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run the prediction so isolated bad words are
                        // absorbed without losing sequence position.
                        exp_r <= exp_step_s;
                        if (word_hit_s) begin
                            miss_cnt_r <= {UW{1'b0}};
                        end else if (miss_last_s) begin
                            state_r    <= ST_HUNT;
                            locked     <= 1'b0;
                            miss_cnt_r <= {UW{1'b0}};
                        end else begin
                            miss_cnt_r <= miss_cnt_r + MISS_ONE;
                        end
                    end
                    default: begin
                        state_r     <= ST_HUNT;
                        locked      <= 1'b0;
                        match_cnt_r <= {MW{1'b0}};
                        miss_cnt_r  <= {UW{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed vector table plus a
// randomized stream compared against a sequence-position reference model.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        reset_a, valid_a, clear_a;
    logic [3:0]  word_a;
    logic        locked_a, pulse_a;
    logic [15:0] count_a;

    // DUT B: 2-bit counter, long unlock window, for saturation
    logic        reset_b, valid_b, clear_b;
    logic [3:0]  word_b;
    logic        locked_b, pulse_b;
    logic [1:0]  count_b;

    lfsr_checker dut_a (
        .clk(clk), .reset(reset_a), .in_valid(valid_a), .in_word(word_a),
        .clear(clear_a), .locked(locked_a), .err_pulse(pulse_a), .err_count(count_a)
    );

    lfsr_checker #(.N(4), .TAPS(4'b1001), .LOCK_CNT(4), .UNLOCK_CNT(8), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset_b), .in_valid(valid_b), .in_word(word_b),
        .clear(clear_b), .locked(locked_b), .err_pulse(pulse_b), .err_count(count_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit       b;
        bit       rst;
        bit       v;
        logic [3:0] w;
        bit       clr;
        bit       l;
        bit       p;
        int       c;
    } vec_t;

    vec_t vecs[$];

    // The maximal-length sequence as listed for TAPS=1001, and each word's position
    logic [3:0] seq_w [15];
    int         pos_of[16];

    task automatic check(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic void add(input bit b, input bit rst, input bit v, input logic [3:0] w,
                                input bit clr, input bit l, input bit p, input int c);
        vec_t t;
        t.b = b; t.rst = rst; t.v = v; t.w = w; t.clr = clr; t.l = l; t.p = p; t.c = c;
        vecs.push_back(t);
    endfunction

    // Reference model state: mode 0=hunt 1=sync 2=locked, idx = position of expected word
    int m_mode, m_idx, m_run, m_miss, m_cnt;
    bit m_pulse;

    task automatic model_step(input bit rst, input bit v, input logic [3:0] w, input bit clr);
        if (rst) begin
            m_mode = 0; m_idx = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (v) begin
                if (m_mode == 0) begin
                    if (w != 4'd0) begin
                        m_idx = (pos_of[w] + 1) % 15; m_run = 0; m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    if (w == seq_w[m_idx]) begin
                        m_idx = (m_idx + 1) % 15;
                        m_run++;
                        if (m_run == 4) begin m_mode = 2; m_miss = 0; end
                    end else if (w != 4'd0) begin
                        m_idx = (pos_of[w] + 1) % 15; m_run = 0;
                    end else begin
                        m_mode = 0;
                    end
                end else begin
                    if (w == seq_w[m_idx]) begin
                        m_miss = 0;
                    end else begin
                        m_pulse = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                        m_miss++;
                        if (m_miss == 3) m_mode = 0;
                    end
                    m_idx = (m_idx + 1) % 15;
                end
            end
            if (clr) m_cnt = 0;
        end
    endtask

    initial begin
        int k;
        int gen_idx;
        int burst;
        bit r_rst, r_v, r_clr;
        logic [3:0] r_w;

        seq_w = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010, 4'b0101,
                  4'b1011, 4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 16; i++) pos_of[i] = 0;
        for (int i = 0; i < 15; i++) pos_of[seq_w[i]] = i;

        reset_a = 1'b1; valid_a = 1'b0; clear_a = 1'b0; word_a = 4'd0;
        reset_b = 1'b1; valid_b = 1'b0; clear_b = 1'b0; word_b = 4'd0;

        // ---- Directed table for DUT A ----
        add(0, 1, 0, 4'd0, 0, 0, 0, 0);
        add(0, 1, 0, 4'd0, 0, 0, 0, 0);
        for (k = 0; k < 4; k++) add(0, 0, 1, seq_w[k], 0, 0, 0, 0);
        add(0, 0, 1, seq_w[4], 0, 1, 0, 0);                 // 5th word locks
        for (k = 5; k <= 48; k++) add(0, 0, 1, seq_w[k % 15], 0, 1, 0, 0);
        add(0, 0, 1, 4'b0000, 0, 1, 1, 1);                   // 1110 replaced by 0000
        add(0, 0, 1, seq_w[50 % 15], 0, 1, 0, 1);            // 1101 matches
        add(0, 0, 1, seq_w[51 % 15], 0, 1, 0, 1);
        add(0, 0, 1, 4'b1111, 0, 1, 1, 2);                   // three wrong words
        add(0, 0, 1, 4'b1111, 0, 1, 1, 3);
        add(0, 0, 1, 4'b1111, 0, 0, 1, 4);
        for (k = 55; k <= 58; k++) add(0, 0, 1, seq_w[k % 15], 0, 0, 0, 4);
        add(0, 0, 1, seq_w[59 % 15], 0, 1, 0, 4);            // relocked
        add(0, 0, 0, 4'b0000, 0, 1, 0, 4);                   // invalid garbage ignored
        add(0, 0, 0, 4'b1111, 0, 1, 0, 4);
        add(0, 0, 1, 4'b1111, 1, 1, 1, 0);                   // clear wins over mismatch
        add(0, 0, 1, seq_w[61 % 15], 0, 1, 0, 0);
        for (k = 62; k <= 71; k++) begin                     // valid toggling
            add(0, 0, 1, seq_w[k % 15], 0, 1, 0, 0);
            add(0, 0, 0, 4'b0110, 0, 1, 0, 0);
        end
        // Hunt phase with zeros and a reseed
        add(0, 1, 0, 4'd0, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0011, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0111, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0101, 0, 0, 0, 0);
        add(0, 0, 1, 4'b1011, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0110, 0, 0, 0, 0);
        add(0, 0, 1, 4'b1100, 0, 0, 0, 0);
        add(0, 0, 1, 4'b1001, 0, 1, 0, 0);
        // Two errors, then reset while locked
        add(0, 0, 1, 4'b1111, 0, 1, 1, 1);
        add(0, 0, 1, 4'b0100, 0, 1, 0, 1);
        add(0, 0, 1, 4'b1111, 0, 1, 1, 2);
        add(0, 1, 1, 4'b0001, 0, 0, 0, 0);                   // reset beats valid input
        add(0, 0, 1, 4'b0010, 0, 0, 0, 0);                   // back in HUNT: full relock needed
        add(0, 0, 1, 4'b0100, 0, 0, 0, 0);
        add(0, 0, 1, 4'b1000, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0001, 0, 0, 0, 0);
        add(0, 0, 1, 4'b0011, 0, 1, 0, 0);
        // ---- DUT B: saturation at 3 ----
        add(1, 1, 0, 4'd0, 0, 0, 0, 0);
        for (k = 0; k < 4; k++) add(1, 0, 1, seq_w[k], 0, 0, 0, 0);
        add(1, 0, 1, seq_w[4], 0, 1, 0, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 1);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 2);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 3);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 3);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 3);
        add(1, 0, 1, seq_w[10], 0, 1, 0, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].b) begin
                reset_a = 1'b0; valid_a = 1'b0; clear_a = 1'b0;
                reset_b = vecs[i].rst; valid_b = vecs[i].v; word_b = vecs[i].w; clear_b = vecs[i].clr;
            end else begin
                reset_a = vecs[i].rst; valid_a = vecs[i].v; word_a = vecs[i].w; clear_a = vecs[i].clr;
            end
            @(posedge clk); #1;
            if (vecs[i].b) begin
                check($sformatf("vec%0d_b_locked", i), int'(locked_b), int'(vecs[i].l));
                check($sformatf("vec%0d_b_pulse", i),  int'(pulse_b),  int'(vecs[i].p));
                check($sformatf("vec%0d_b_count", i),  int'(count_b),  vecs[i].c);
            end else begin
                check($sformatf("vec%0d_locked", i), int'(locked_a), int'(vecs[i].l));
                check($sformatf("vec%0d_pulse", i),  int'(pulse_a),  int'(vecs[i].p));
                check($sformatf("vec%0d_count", i),  int'(count_a),  vecs[i].c);
            end
        end
        valid_b = 1'b0; clear_b = 1'b0;

        // ---- Randomized stream against the reference model ----
        reset_a = 1'b1; valid_a = 1'b0; clear_a = 1'b0;
        model_step(1'b1, 1'b0, 4'd0, 1'b0);
        @(posedge clk); #1;
        check("rand_reset_count", int'(count_a), m_cnt);
        gen_idx = int'($urandom_range(0, 14));
        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            r_rst = ($urandom_range(0, 599) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 47) == 0);
            if ($urandom_range(0, 99) == 0) gen_idx = (gen_idx + int'($urandom_range(1, 14))) % 15;
            if ($urandom_range(0, 149) == 0) burst = int'($urandom_range(2, 4));
            if (r_v) begin
                r_w = seq_w[gen_idx];
                gen_idx = (gen_idx + 1) % 15;
                if (burst > 0) begin
                    r_w = r_w ^ 4'(1 + $urandom_range(0, 14));
                    burst--;
                end else if ($urandom_range(0, 19) == 0) begin
                    r_w = 4'($urandom_range(0, 15));
                end
            end else begin
                r_w = 4'($urandom_range(0, 15));
            end
            reset_a = r_rst; valid_a = r_v; word_a = r_w; clear_a = r_clr;
            model_step(r_rst, r_v, r_w, r_clr);
            @(posedge clk); #1;
            check($sformatf("rand%0d_locked", n), int'(locked_a), m_mode == 2 ? 1 : 0);
            check($sformatf("rand%0d_pulse", n),  int'(pulse_a),  int'(m_pulse));
            check($sformatf("rand%0d_count", n),  int'(count_a),  m_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
